// File: rtl/payload_pkg.sv
// rtl/payload_pkg.sv - shared types and constants for the payload byte feeder
package payload_pkg;

  localparam int FEED_DATA_W = 64;
  localparam int CHAR_W      = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SOD,
    ST_EMIT,
    ST_EOD
  } feeder_state_e;

endpackage

// File: rtl/char_onehot_dec.sv
// rtl/char_onehot_dec.sv - 8-to-256 one-hot character decoder gated by en
module char_onehot_dec
  import payload_pkg::*;
(
  input  logic              en,
  input  logic [7:0]        char_in,
  output logic [CHAR_W-1:0] char_hot
);

  always_comb begin
    char_hot = '0;
    if (en) char_hot[char_in] = 1'b1;
  end

endmodule

// File: rtl/payload_byte_feeder.sv
// rtl/payload_byte_feeder.sv - serialises a wide payload stream into one byte per clock
// with sod/en/eod framing for the NFA payload engines.
module payload_byte_feeder
  import payload_pkg::*;
#(
  parameter int DATA_W = FEED_DATA_W,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              sod,
  output logic              en,
  output logic              eod,
  output logic [7:0]        byte_out,
  output logic [CHAR_W-1:0] char_hot,
  output logic [CNT_W-1:0]  byte_ofs
);

  feeder_state_e     state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] rem_q, rem_d;
  logic              last_q, last_d;
  logic              sod_q, sod_d;
  logic              en_q, en_d;
  logic              eod_q, eod_d;
  logic [7:0]        byte_q, byte_d;
  logic [CNT_W-1:0]  ofs_q, ofs_d;
  logic [CNT_W-1:0]  ofs_inc;

  logic              accept;
  logic [KEEP_W-1:0] sel_keep;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] lane_bit;
  logic [KEEP_W-1:0] rem_next;
  logic [7:0]        lane_byte;
  logic              lane_hit;

  // Ready depends on registered state only; the held beat is exhausted and more follows.
  assign s_tready = ~rst & ((state_q == ST_IDLE) |
                            ((state_q == ST_EMIT) & ~(|rem_q) & ~last_q));
  assign accept   = s_tvalid & s_tready;

  // An accepted beat feeds the encoder directly so the next packet byte follows without a bubble.
  assign sel_keep = accept ? s_tkeep : rem_q;
  assign sel_data = accept ? s_tdata : data_q;

  always_comb begin
    lane_byte = '0;
    lane_bit  = '0;
    for (int i = KEEP_W - 1; i >= 0; i--) begin
      if (sel_keep[i]) begin
        lane_byte   = sel_data[8*i +: 8];
        lane_bit    = '0;
        lane_bit[i] = 1'b1;
      end
    end
  end

  assign lane_hit = |sel_keep;
  assign rem_next = sel_keep & ~lane_bit;
  assign ofs_inc  = (&ofs_q) ? ofs_q : ofs_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    last_d  = last_q;
    sod_d   = 1'b0;
    en_d    = 1'b0;
    eod_d   = 1'b0;
    byte_d  = byte_q;
    ofs_d   = en_q ? ofs_inc : ofs_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = s_tdata;
          rem_d   = s_tkeep;
          last_d  = s_tlast;
          sod_d   = 1'b1;
          ofs_d   = '0;
          state_d = ST_SOD;
        end
      end

      ST_SOD: begin
        if (lane_hit) begin
          en_d    = 1'b1;
          byte_d  = lane_byte;
          rem_d   = rem_next;
          state_d = ST_EMIT;
        end else begin
          eod_d   = 1'b1;
          state_d = ST_EOD;
        end
      end

      ST_EMIT: begin
        if (|rem_q) begin
          en_d   = 1'b1;
          byte_d = lane_byte;
          rem_d  = rem_next;
        end else if (last_q) begin
          eod_d   = 1'b1;
          state_d = ST_EOD;
        end else if (accept) begin
          data_d = s_tdata;
          last_d = s_tlast;
          rem_d  = rem_next;
          if (lane_hit) begin
            en_d   = 1'b1;
            byte_d = lane_byte;
          end else if (s_tlast) begin
            eod_d   = 1'b1;
            state_d = ST_EOD;
          end
        end
      end

      ST_EOD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      sod_q   <= 1'b0;
      en_q    <= 1'b0;
      eod_q   <= 1'b0;
      byte_q  <= '0;
      ofs_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      sod_q   <= sod_d;
      en_q    <= en_d;
      eod_q   <= eod_d;
      byte_q  <= byte_d;
      ofs_q   <= ofs_d;
    end
  end

  assign sod      = sod_q;
  assign en       = en_q;
  assign eod      = eod_q;
  assign byte_out = byte_q;
  assign byte_ofs = ofs_q;

  char_onehot_dec u_char_dec (
    .en       (en_q),
    .char_in  (byte_q),
    .char_hot (char_hot)
  );

endmodule
